// File: rtl/vehicle_sensor_conditioner.sv
// Loop-detector front end for the traffic controller: it synchronises and debounces the
// contact, latches the vehicle call, and limits how long a stuck sensor can hold the country green.
module vehicle_sensor_conditioner #(
  parameter int DEB_CYCLES     = 4,
  parameter int MAX_SERVE      = 10,
  parameter int LOCKOUT_CYCLES = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_raw,
  input  logic SC,
  output logic S,
  output logic sensor_stable
);

  localparam logic [15:0] DEB_TC  = 16'(DEB_CYCLES - 1);
  localparam logic [15:0] SERV_TC = 16'(MAX_SERVE - 1);
  localparam logic [15:0] LOCK_TC = 16'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, SERVE, LOCKOUT} state_t;

  logic        s1, s2;
  logic [15:0] deb_cnt;
  logic [15:0] timer, timer_n;
  state_t      state, state_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      deb_cnt       <= '0;
      sensor_stable <= 1'b0;
    end else begin
      s1 <= sensor_raw;
      s2 <= s1;
      if (s2 == sensor_stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_TC) begin
        sensor_stable <= s2;
        deb_cnt       <= '0;
      end else begin
        deb_cnt <= deb_cnt + 16'd1;
      end
    end
  end

  // The timer stops at all-ones rather than wrapping; every terminal count is below that value.
  always_comb begin
    state_n = state;
    timer_n = (timer == 16'hffff) ? timer : timer + 16'd1;
    case (state)
      IDLE: begin
        timer_n = '0;
        if (sensor_stable) state_n = REQ;
      end
      REQ: begin
        timer_n = '0;
        if (SC) state_n = SERVE;
      end
      SERVE: begin
        // Sensor release has priority over timeout, so a clean departure never enters lockout.
        if (!sensor_stable) begin
          state_n = IDLE;
          timer_n = '0;
        end else if (timer == SERV_TC) begin
          state_n = LOCKOUT;
          timer_n = '0;
        end
      end
      LOCKOUT: begin
        if (timer == LOCK_TC) begin
          state_n = sensor_stable ? REQ : IDLE;
          timer_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      S     <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      S     <= (state_n == REQ) || (state_n == SERVE);
    end
  end

endmodule
